// File: rtl/btb_predictor_param_if.sv
`default_nettype none
// ============================================================================
//  Module   : btb_predictor_param_if
//  Purpose  : Fetch-lookup / execute-update bundle for btb_predictor_param.
//             The master side is the pipeline, the slave side is the predictor.
//  Revision : 1.0  initial release
// ============================================================================
interface btb_predictor_param_if #(
  parameter int XLEN  = 32,
  parameter int GHR_W = 6
);
  // Fetch-stage lookup
  logic [XLEN-1:0]  if_pc_i;
  logic             pred_hit_o;
  logic             pred_taken_o;
  logic [XLEN-1:0]  pred_target_o;
  logic [GHR_W-1:0] pred_ghr_o;

  // Execute-stage resolution
  logic             upd_valid_i;
  logic [XLEN-1:0]  upd_pc_i;
  logic             upd_is_cond_i;
  logic             upd_taken_i;
  logic [XLEN-1:0]  upd_target_i;
  logic             upd_mispred_i;
  logic [GHR_W-1:0] upd_ghr_i;

  // Statistics
  logic [31:0]      perf_br_o;
  logic [31:0]      perf_misp_o;

  modport master (
    output if_pc_i, upd_valid_i, upd_pc_i, upd_is_cond_i, upd_taken_i,
           upd_target_i, upd_mispred_i, upd_ghr_i,
    input  pred_hit_o, pred_taken_o, pred_target_o, pred_ghr_o,
           perf_br_o, perf_misp_o
  );

  modport slave (
    input  if_pc_i, upd_valid_i, upd_pc_i, upd_is_cond_i, upd_taken_i,
           upd_target_i, upd_mispred_i, upd_ghr_i,
    output pred_hit_o, pred_taken_o, pred_target_o, pred_ghr_o,
           perf_br_o, perf_misp_o
  );
endinterface
`default_nettype wire

// File: rtl/btb_predictor_param.sv
`default_nettype none
// ============================================================================
//  Module   : btb_predictor_param
//  Purpose  : Direct-mapped branch target buffer with per-entry saturating
//             direction counters, zero-latency lookup and branch statistics.
//  Options  : GSHARE_EN - moves the direction counters into a separate table
//             indexed by idx XOR global history (non-speculative GHR).
//  Revision : 1.0  initial release
// ============================================================================
module btb_predictor_param #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int TAG_W   = 8,
  parameter int CNT_W   = 2,
  parameter int GHR_W   = 6
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  btb_predictor_param_if.slave  bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_LO = IDX_W + 2;
  localparam int TAG_HI = IDX_W + TAG_W + 1;

  // Counter encodings: saturate high, weakly taken, weakly not-taken
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_WT  = {1'b1, {(CNT_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_WNT = {1'b0, {(CNT_W-1){1'b1}}};

  // Table storage. Tags and targets need no reset: valid gates them.
  logic [ENTRIES-1:0] valid_tab;
  logic [TAG_W-1:0]   tag_tab [ENTRIES];
  logic [XLEN-1:0]    tgt_tab [ENTRIES];
  logic [CNT_W-1:0]   cnt_tab [ENTRIES];

  // Statistics
  logic [31:0] perf_br;
  logic [31:0] perf_misp;

  // Lookup side
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] lk_cidx;
  logic             lk_hit;

  // Update side
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  logic [IDX_W-1:0] up_cidx;
  logic             up_hit;
  logic [CNT_W-1:0] cnt_cur;
  logic [CNT_W-1:0] cnt_nxt;
  logic             cnt_we;
  logic             alloc;
  logic             tgt_we;

  assign lk_idx = bus.if_pc_i[IDX_W+1:2];
  assign lk_tag = bus.if_pc_i[TAG_HI:TAG_LO];
  assign up_idx = bus.upd_pc_i[IDX_W+1:2];
  assign up_tag = bus.upd_pc_i[TAG_HI:TAG_LO];

  // Byte offset and PC bits above the tag do not participate in the lookup
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.if_pc_i[1:0],  bus.if_pc_i[XLEN-1:TAG_HI+1],
                            bus.upd_pc_i[1:0], bus.upd_pc_i[XLEN-1:TAG_HI+1]};

`ifdef GSHARE_EN
  logic [GHR_W-1:0] ghr;

  // History is folded into the low index bits of the counter table only;
  // the update side uses the history that was live when it was predicted.
  assign lk_cidx        = lk_idx ^ IDX_W'(ghr);
  assign up_cidx        = up_idx ^ IDX_W'(bus.upd_ghr_i);
  assign bus.pred_ghr_o = ghr;

  // Non-speculative global history: shifts only on resolved conditionals
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ghr <= '0;
    end else if (bus.upd_valid_i && bus.upd_is_cond_i) begin
      ghr <= (ghr << 1) | GHR_W'(bus.upd_taken_i);
    end
  end
`else
  assign lk_cidx        = lk_idx;
  assign up_cidx        = up_idx;
  assign bus.pred_ghr_o = '0;

  logic unused_ghr;
  assign unused_ghr = ^bus.upd_ghr_i;
`endif

  // Combinational lookup; reads pre-update contents (no write bypass)
  assign lk_hit            = valid_tab[lk_idx] && (tag_tab[lk_idx] == lk_tag);
  assign bus.pred_hit_o    = lk_hit;
  assign bus.pred_taken_o  = lk_hit && cnt_tab[lk_cidx][CNT_W-1];
  assign bus.pred_target_o = lk_hit ? tgt_tab[lk_idx] : '0;

  assign up_hit = valid_tab[up_idx] && (tag_tab[up_idx] == up_tag);
  assign cnt_cur = cnt_tab[up_cidx];

  // Write enables: not-taken misses leave the table untouched
  assign alloc  = bus.upd_valid_i && !up_hit && bus.upd_taken_i;
  assign cnt_we = bus.upd_valid_i && (up_hit || bus.upd_taken_i);
  assign tgt_we = bus.upd_valid_i && bus.upd_taken_i;

  // Next counter value: saturating step on a hit, fresh value on allocation
  always_comb begin
    cnt_nxt = cnt_cur;
    if (up_hit) begin
      if (!bus.upd_is_cond_i) begin
        cnt_nxt = CNT_MAX;
      end else if (bus.upd_taken_i) begin
        if (cnt_cur != CNT_MAX) cnt_nxt = cnt_cur + 1'b1;
      end else begin
        if (cnt_cur != '0) cnt_nxt = cnt_cur - 1'b1;
      end
    end else begin
      cnt_nxt = bus.upd_is_cond_i ? CNT_WT : CNT_MAX;
    end
  end

  // Valid bits and direction counters; reset clears them and blocks any write
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_tab <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        cnt_tab[i] <= CNT_WNT;
      end
    end else begin
      if (alloc) valid_tab[up_idx] <= 1'b1;
      if (cnt_we) cnt_tab[up_cidx] <= cnt_nxt;
    end
  end

  // Tag and target storage; reset still suppresses the write that cycle
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (alloc)  tag_tab[up_idx] <= up_tag;
      if (tgt_we) tgt_tab[up_idx] <= bus.upd_target_i;
    end
  end

  // Resolved-branch and mispredict counters, free-running modulo 2^32
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_br   <= '0;
      perf_misp <= '0;
    end else if (bus.upd_valid_i) begin
      perf_br <= perf_br + 32'd1;
      if (bus.upd_mispred_i) perf_misp <= perf_misp + 32'd1;
    end
  end

  assign bus.perf_br_o   = perf_br;
  assign bus.perf_misp_o = perf_misp;

endmodule
`default_nettype wire

// File: tb/tb_btb_predictor_param.sv
`default_nettype none
// ============================================================================
//  Module   : tb_btb_predictor_param
//  Purpose  : Directed vector bench for btb_predictor_param (ENTRIES=16,
//             GHR_W=2). With GSHARE_EN the alternating-pattern test runs.
//  Revision : 1.0  initial release
// ============================================================================
module tb_btb_predictor_param;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 16;
  localparam int GHR_W   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  btb_predictor_param_if #(.XLEN(XLEN), .GHR_W(GHR_W)) bus ();

  btb_predictor_param #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .TAG_W(8), .CNT_W(2), .GHR_W(GHR_W)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        uv;
    logic [31:0] upc;
    logic        uc;
    logic        ut;
    logic [31:0] utg;
    logic        um;
    logic [31:0] lpc;
    logic        eh;
    logic        et;
    logic [31:0] etg;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_upd(input logic v, input logic [31:0] pc, input logic c,
                         input logic t, input logic [31:0] tg, input logic m);
    bus.upd_valid_i   = v;
    bus.upd_pc_i      = pc;
    bus.upd_is_cond_i = c;
    bus.upd_taken_i   = t;
    bus.upd_target_i  = tg;
    bus.upd_mispred_i = m;
  endtask

  task automatic idle();
    set_upd(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lookup(input string name, input logic h, input logic t, input logic [31:0] tg);
    check({name, ".hit"},    {31'd0, bus.pred_hit_o},   {31'd0, h});
    check({name, ".taken"},  {31'd0, bus.pred_taken_o}, {31'd0, t});
    check({name, ".target"}, bus.pred_target_o, tg);
  endtask

  task automatic addv(input logic uv, input logic [31:0] upc, input logic uc, input logic ut,
                      input logic [31:0] utg, input logic um, input logic [31:0] lpc,
                      input logic eh, input logic et, input logic [31:0] etg);
    vec_t v;
    v = '{uv, upc, uc, ut, utg, um, lpc, eh, et, etg};
    vecs.push_back(v);
  endtask

  initial begin
    idle();
    bus.if_pc_i   = 32'h100;
    bus.upd_ghr_i = '0;
    rst = 1'b1;
    tick();
    tick();
    check_lookup("in_reset", 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    #1;
    check_lookup("after_reset", 1'b0, 1'b0, 32'h0);
    check("reset.perf_br",   bus.perf_br_o,   32'd0);
    check("reset.perf_misp", bus.perf_misp_o, 32'd0);
    check("reset.ghr",       {30'd0, bus.pred_ghr_o}, 32'd0);

`ifdef GSHARE_EN
    begin
      logic [GHR_W-1:0] ghr_m;
      logic             outcome;
      ghr_m = '0;
      // Alternating T,N at one PC: two history contexts learn opposite outcomes
      for (int i = 0; i < 16; i++) begin
        outcome = (i % 2 == 0);
        bus.if_pc_i   = 32'h20;
        bus.upd_ghr_i = ghr_m;
        set_upd(1'b1, 32'h20, 1'b1, outcome, 32'h40, 1'b0);
        #1;
        check($sformatf("gshare[%0d].ghr", i), {30'd0, bus.pred_ghr_o}, {30'd0, ghr_m});
        if (i >= 4)
          check($sformatf("gshare[%0d].pred", i), {31'd0, bus.pred_taken_o}, {31'd0, outcome});
        tick();
        ghr_m = {ghr_m[GHR_W-2:0], outcome};
      end
      idle();
      #1;
      check("gshare.perf_br", bus.perf_br_o, 32'd16);
    end
`else
    // Each vector: update and lookup are presented together, the lookup is
    // checked before the edge (pre-update contents), then the clock advances.
    //    uv  upc        c  t  utg         m  lpc        hit tk target
    addv(0, 32'h0,    0, 0, 32'h0,    0, 32'h100, 0, 0, 32'h0);     // cold miss
    addv(1, 32'h100,  1, 1, 32'h80,   1, 32'h100, 0, 0, 32'h0);     // alloc, same-cycle miss
    addv(0, 32'h0,    0, 0, 32'h0,    0, 32'h100, 1, 1, 32'h80);    // cnt 2
    addv(1, 32'h100,  1, 0, 32'h0,    1, 32'h100, 1, 1, 32'h80);    // -> 1
    addv(1, 32'h100,  1, 0, 32'h0,    0, 32'h100, 1, 0, 32'h80);    // -> 0
    addv(0, 32'h0,    0, 0, 32'h0,    0, 32'h100, 1, 0, 32'h80);
    addv(1, 32'h100,  1, 0, 32'h0,    0, 32'h100, 1, 0, 32'h80);    // sat at 0
    addv(1, 32'h100,  1, 1, 32'h80,   0, 32'h100, 1, 0, 32'h80);    // -> 1
    addv(1, 32'h100,  1, 1, 32'h80,   0, 32'h100, 1, 0, 32'h80);    // -> 2
    addv(1, 32'h100,  1, 1, 32'h80,   1, 32'h100, 1, 1, 32'h80);    // -> 3
    addv(1, 32'h100,  1, 1, 32'h84,   0, 32'h100, 1, 1, 32'h80);    // sat 3, new target
    addv(1, 32'h100,  1, 0, 32'h0,    0, 32'h100, 1, 1, 32'h84);    // -> 2
    addv(0, 32'h0,    0, 0, 32'h0,    0, 32'h100, 1, 1, 32'h84);
    addv(1, 32'h140,  1, 1, 32'h200,  1, 32'h140, 0, 0, 32'h0);     // alias evicts 0x100
    addv(0, 32'h0,    0, 0, 32'h0,    0, 32'h100, 0, 0, 32'h0);
    addv(0, 32'h0,    0, 0, 32'h0,    0, 32'h140, 1, 1, 32'h200);
    addv(1, 32'h300,  1, 0, 32'h0,    0, 32'h140, 1, 1, 32'h200);   // NT miss: no alloc
    addv(0, 32'h0,    0, 0, 32'h0,    0, 32'h300, 0, 0, 32'h0);
    addv(0, 32'h0,    0, 0, 32'h0,    0, 32'h140, 1, 1, 32'h200);
    addv(1, 32'h208,  0, 1, 32'h1000, 0, 32'h208, 0, 0, 32'h0);     // jump alloc -> max
    addv(0, 32'h0,    0, 0, 32'h0,    0, 32'h208, 1, 1, 32'h1000);
    addv(1, 32'h208,  1, 0, 32'h0,    0, 32'h208, 1, 1, 32'h1000);  // 3 -> 2
    addv(0, 32'h0,    0, 0, 32'h0,    0, 32'h208, 1, 1, 32'h1000);
    addv(0, 32'h400,  1, 1, 32'h700,  1, 32'h400, 0, 0, 32'h0);     // invalid update ignored
    addv(0, 32'h0,    0, 0, 32'h0,    0, 32'h400, 0, 0, 32'h0);
    addv(0, 32'h0,    0, 0, 32'h0,    0, 32'h143, 1, 1, 32'h200);   // PC[1:0] ignored

    for (int i = 0; i < vecs.size(); i++) begin
      set_upd(vecs[i].uv, vecs[i].upc, vecs[i].uc, vecs[i].ut, vecs[i].utg, vecs[i].um);
      bus.if_pc_i = vecs[i].lpc;
      #1;
      check_lookup($sformatf("vec%0d", i), vecs[i].eh, vecs[i].et, vecs[i].etg);
      check($sformatf("vec%0d.ghr", i), {30'd0, bus.pred_ghr_o}, 32'd0);
      tick();
    end

    // Same-cycle lookup and update of idx 5: old data now, new data next cycle
    bus.if_pc_i = 32'h14;
    set_upd(1'b1, 32'h14, 1'b1, 1'b1, 32'h500, 1'b0);
    #1;
    check_lookup("idx5.alloc_same", 1'b0, 1'b0, 32'h0);
    tick();
    idle();
    #1;
    check_lookup("idx5.alloc_next", 1'b1, 1'b1, 32'h500);
    set_upd(1'b1, 32'h14, 1'b1, 1'b1, 32'h600, 1'b0);
    #1;
    check_lookup("idx5.upd_same", 1'b1, 1'b1, 32'h500);
    tick();
    idle();
    #1;
    check_lookup("idx5.upd_next", 1'b1, 1'b1, 32'h600);

    // 13 table updates + 2 above; mispredicts flagged on 4 valid updates
    check("perf_br",   bus.perf_br_o,   32'd15);
    check("perf_misp", bus.perf_misp_o, 32'd4);

    // Mispredict counter wrap from all-ones
    set_upd(1'b1, 32'h14, 1'b1, 1'b1, 32'h600, 1'b1);
    force dut.perf_misp = 32'hFFFF_FFFF;
    release dut.perf_misp;
    tick();
    idle();
    #1;
    check("wrap.perf_misp", bus.perf_misp_o, 32'd0);
    check("wrap.perf_br",   bus.perf_br_o,   32'd16);

    // Reset coinciding with a taken update: reset wins, nothing is written
    rst = 1'b1;
    set_upd(1'b1, 32'h100, 1'b1, 1'b1, 32'h900, 1'b1);
    tick();
    rst = 1'b0;
    idle();
    bus.if_pc_i = 32'h100;
    #1;
    check_lookup("rst_mid.0x100", 1'b0, 1'b0, 32'h0);
    bus.if_pc_i = 32'h14;
    #1;
    check_lookup("rst_mid.0x14", 1'b0, 1'b0, 32'h0);
    check("rst_mid.perf_br",   bus.perf_br_o,   32'd0);
    check("rst_mid.perf_misp", bus.perf_misp_o, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
